// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Owns the fetch PC, issues requests over a req/gnt/rvalid handshake,
// buffers returned words in an in-order queue and presents the head as
// {RD_out, PC_out}. Redirects from ID flush the queue and drop any
// responses still owed by memory.
// Optional feature: define IF_DELAY_SLOT_EN to keep the oldest allocated
// entry on redirect (MIPS branch delay slot).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_reg,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] RD_out,
  output logic [31:0] PC_out
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = AW + 1;
  // Drop counter only has to cover responses the memory still owes us.
  localparam int DW = 8;
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // r_wr: next slot to allocate, r_rd: head, r_fill: oldest not-ready slot.
  logic [31:0]   r_fetch_pc;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_fill;
  logic [DW-1:0] r_drop;
`ifdef IF_DELAY_SLOT_EN
  logic          r_pend;
  logic [31:0]   r_pend_pc;
`endif

  logic [31:0]           w_ent_pc   [FIFO_DEPTH];
  logic [31:0]           w_ent_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] w_ent_ready;

  logic [PW-1:0] w_count;
  logic [PW-1:0] w_outst;
  logic [PW-1:0] w_fill_next;
  logic [PW-1:0] w_rd_next1;
  logic [AW-1:0] w_rd_idx;
  logic          w_head_ready;
  logic          w_grant;
  logic          w_drop_rsp;
  logic          w_fill_rsp;
  logic          w_pop;
  logic [DW-1:0] w_drop_dec;

  assign w_count      = r_wr - r_rd;
  assign w_outst      = r_wr - r_fill;
  assign w_rd_idx     = r_rd[AW-1:0];
  assign w_rd_next1   = r_rd + PW'(1);
  assign w_head_ready = (w_count != '0) && w_ent_ready[w_rd_idx];

  assign imem_req  = !rst && (w_count < DEPTH_P);
  assign imem_addr = r_fetch_pc;
  assign w_grant   = imem_req && imem_gnt;

  // A response either burns one pending drop or completes the oldest
  // not-ready entry; with nothing owed it is ignored.
  assign w_drop_rsp  = imem_rvalid && (r_drop != '0);
  assign w_fill_rsp  = imem_rvalid && (r_drop == '0) && (w_outst != '0);
  assign w_fill_next = r_fill + PW'(w_fill_rsp);
  assign w_drop_dec  = r_drop - DW'(w_drop_rsp);

  assign w_pop = en_reg && w_head_ready && !redirect;

  // Head is shown only once its word has arrived; otherwise a NOP.
  assign RD_out = w_head_ready ? w_ent_data[w_rd_idx] : 32'h0;
  assign PC_out = w_head_ready ? (w_ent_pc[w_rd_idx] + 32'd4) : 32'h0;

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [31:0] r_pc;
      logic [31:0] r_data;
      logic        r_ready;

      // Capture the fetch PC at grant and the word when its response lands.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pc    <= '0;
          r_data  <= '0;
          r_ready <= 1'b0;
        end else begin
          if (w_grant && (r_wr[AW-1:0] == AW'(gi))) begin
            r_pc    <= r_fetch_pc;
            r_ready <= 1'b0;
          end
          if (w_fill_rsp && (r_fill[AW-1:0] == AW'(gi))) begin
            r_data  <= imem_rdata;
            r_ready <= 1'b1;
          end
        end
      end

      assign w_ent_pc[gi]    = r_pc;
      assign w_ent_data[gi]  = r_data;
      assign w_ent_ready[gi] = r_ready;
    end
  endgenerate

  // Fetch PC, queue pointers and drop accounting; redirect outranks pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_wr       <= '0;
      r_rd       <= '0;
      r_fill     <= '0;
      r_drop     <= '0;
`ifdef IF_DELAY_SLOT_EN
      r_pend     <= 1'b0;
      r_pend_pc  <= '0;
`endif
    end else if (redirect) begin
`ifdef IF_DELAY_SLOT_EN
      if (w_count != '0) begin
        // Keep the head as the delay slot; everything younger is flushed.
        r_fetch_pc <= redirect_pc;
        r_pend     <= 1'b0;
        r_wr       <= w_rd_next1;
        if (w_fill_next == r_rd) begin
          r_fill <= r_rd;
          r_drop <= w_drop_dec + DW'(r_wr - w_rd_next1) + DW'(w_grant);
        end else begin
          r_fill <= w_rd_next1;
          r_drop <= w_drop_dec + DW'(r_wr - w_fill_next) + DW'(w_grant);
        end
      end else begin
        // Nothing allocated: the delay slot is the next fetch at fetch_pc.
        r_drop <= w_drop_dec;
        if (w_grant) begin
          r_wr       <= r_wr + PW'(1);
          r_fetch_pc <= redirect_pc;
          r_pend     <= 1'b0;
        end else begin
          r_pend    <= 1'b1;
          r_pend_pc <= redirect_pc;
        end
      end
`else
      // Full flush: every entry still waiting for memory becomes a drop,
      // as does a request granted in this very cycle.
      r_fetch_pc <= redirect_pc;
      r_wr       <= r_rd;
      r_fill     <= r_rd;
      r_drop     <= w_drop_dec + DW'(r_wr - w_fill_next) + DW'(w_grant);
`endif
    end else begin
      if (w_grant) begin
        r_wr <= r_wr + PW'(1);
`ifdef IF_DELAY_SLOT_EN
        r_fetch_pc <= r_pend ? r_pend_pc : (r_fetch_pc + 32'd4);
        r_pend     <= 1'b0;
`else
        r_fetch_pc <= r_fetch_pc + 32'd4;
`endif
      end
      r_rd   <= r_rd + PW'(w_pop);
      r_fill <= w_fill_next;
      r_drop <= w_drop_dec;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios plus a randomized run,
// all checked against a program-order fetch/delivery model.
module tb_if_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_reg = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] RD_out;
  logic [31:0] PC_out;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en_reg      (en_reg),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .RD_out      (RD_out),
    .PC_out      (PC_out)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t mq[$];
  int   cyc = 0;
  int   gnt_pct = 100;
  int   lat_min = 1;
  int   lat_max = 1;

  // Program-order model: next address to be granted, next PC to be
  // delivered, and the number of words granted but not yet delivered.
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] exp_pc = 32'h0;
  int          live = 0;
  int          n_deliv = 0;

  logic        s_req, s_grant, s_pop, s_rvalid;
  logic [31:0] s_addr, s_rd, s_pc;
  logic [31:0] deliv_pc[$];
  logic [31:0] grant_addr[$];

  // Aligned addresses never map to zero, so RD_out != 0 marks a real word.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic step(input logic r, input logic en, input logic rd,
                      input logic [31:0] rpc);
    rsp_t e;
    @(negedge clk);
    rst = r;
    en_reg = en;
    redirect = rd;
    redirect_pc = rpc;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (!r && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata = word_at(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
    end
    #1;
    s_req = imem_req;
    s_addr = imem_addr;
    s_rd = RD_out;
    s_pc = PC_out;
    s_rvalid = imem_rvalid;
    s_grant = imem_req && imem_gnt;
    s_pop = 1'b0;
    if (r) begin
      checks++;
      if (imem_req !== 1'b0) begin
        errors++;
        $display("FAIL req_in_reset: imem_req=%b required 0", imem_req);
      end
      mq.delete();
      exp_fetch = 32'h0;
      exp_pc = 32'h0;
      live = 0;
    end else begin
      checks++;
      if (imem_req !== (live < DEPTH)) begin
        errors++;
        $display("FAIL req_alloc: cyc=%0d imem_req=%b required %b (live=%0d)",
                 cyc, imem_req, (live < DEPTH), live);
      end
      if (RD_out == 32'h0) begin
        checks++;
        if (PC_out !== 32'h0) begin
          errors++;
          $display("FAIL nop_pc: cyc=%0d PC_out=%h required 0", cyc, PC_out);
        end
      end
      if (imem_rvalid) void'(mq.pop_front());
      if (s_grant) begin
        checks++;
        if (imem_addr !== exp_fetch) begin
          errors++;
          $display("FAIL grant_addr: cyc=%0d imem_addr=%h required %h",
                   cyc, imem_addr, exp_fetch);
        end
        grant_addr.push_back(imem_addr);
        exp_fetch = exp_fetch + 32'd4;
        e.addr = imem_addr;
        e.due = cyc + int'($urandom_range(lat_max, lat_min));
        mq.push_back(e);
      end
      if (rd) begin
        exp_fetch = rpc;
        exp_pc = rpc;
        live = 0;
      end else begin
        if (s_grant) live++;
        if (en && RD_out != 32'h0) begin
          s_pop = 1'b1;
          checks++;
          if (RD_out !== word_at(exp_pc) || PC_out !== exp_pc + 32'd4) begin
            errors++;
            $display("FAIL deliver: cyc=%0d RD_out=%h PC_out=%h required %h %h",
                     cyc, RD_out, PC_out, word_at(exp_pc), exp_pc + 32'd4);
          end
          deliv_pc.push_back(PC_out);
          exp_pc = exp_pc + 32'd4;
          live--;
          n_deliv++;
        end
      end
    end
    $display("cyc=%0d rst=%b en=%b redir=%b req=%b addr=%h gnt=%b rvalid=%b RD=%h PC=%h",
             cyc, r, en, rd, s_req, s_addr, imem_gnt, s_rvalid, s_rd, s_pc);
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    deliv_pc.delete();
    grant_addr.delete();
  endtask

  task automatic test_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (s_rd !== 32'h0 || s_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: RD_out=%h PC_out=%h required 0 0", s_rd, s_pc);
    end
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h required 1 00000000", s_req, s_addr);
    end
  endtask

  task automatic test_basic_stream();
    int first;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    first = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_pop && first < 0) first = i;
    end
    checks++;
    if (first != 2) begin
      errors++;
      $display("FAIL first_latency: first delivery cycle=%0d required 2", first);
    end
    checks++;
    if (grant_addr.size() < 3 || deliv_pc.size() < 3) begin
      errors++;
      $display("FAIL stream_count: grants=%0d delivered=%0d required >=3 each",
               grant_addr.size(), deliv_pc.size());
    end else if (grant_addr[0] !== 32'h0 || grant_addr[1] !== 32'h4 || grant_addr[2] !== 32'h8 ||
                 deliv_pc[0] !== 32'h4 || deliv_pc[1] !== 32'h8 || deliv_pc[2] !== 32'hC) begin
      errors++;
      $display("FAIL stream_order: addr %h %h %h PC %h %h %h required 0 4 8 / 4 8 c",
               grant_addr[0], grant_addr[1], grant_addr[2],
               deliv_pc[0], deliv_pc[1], deliv_pc[2]);
    end
  endtask

  task automatic test_hold();
    int n;
    logic [31:0] held;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    n = 0;
    held = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (s_grant) n++;
      if (i == 2) held = s_rd;
    end
    checks++;
    if (n != DEPTH || s_req !== 1'b0) begin
      errors++;
      $display("FAIL hold_grants: grants=%0d req=%b required %0d 0", n, s_req, DEPTH);
    end
    checks++;
    if (s_rd !== held || s_rd !== word_at(32'h0) || s_pc !== 32'h4) begin
      errors++;
      $display("FAIL hold_stable: RD_out=%h PC_out=%h required %h 00000004",
               s_rd, s_pc, word_at(32'h0));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (deliv_pc.size() < 2 || deliv_pc[0] !== 32'h4 || deliv_pc[1] !== 32'h8) begin
      errors++;
      $display("FAIL hold_release: delivered=%0d required PCs 4 then 8", deliv_pc.size());
    end
  endtask

  task automatic test_redirect_inflight();
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL redir_addr: req=%b addr=%h required 1 00000100", s_req, s_addr);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (deliv_pc.size() < 1 || deliv_pc[0] !== 32'h0000_0104) begin
      errors++;
      $display("FAIL redir_first_pc: delivered=%0d first PC required 00000104", deliv_pc.size());
    end
  endtask

  task automatic test_redirect_same_cycle();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    checks++;
    if (s_grant !== 1'b1 || s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_setup: grant=%b rvalid=%b required 1 1", s_grant, s_rvalid);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (s_rd !== 32'h0 || s_pc !== 32'h0 || s_req !== 1'b1 || s_addr !== 32'h0000_0200) begin
      errors++;
      $display("FAIL same_cycle_empty: RD=%h PC=%h req=%b addr=%h required 0 0 1 00000200",
               s_rd, s_pc, s_req, s_addr);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (deliv_pc.size() < 1 || deliv_pc[0] !== 32'h0000_0204) begin
      errors++;
      $display("FAIL same_cycle_first_pc: delivered=%0d first PC required 00000204", deliv_pc.size());
    end
  endtask

  task automatic test_wrap();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    grant_addr.delete();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (grant_addr.size() < 2 || grant_addr[0] !== 32'hFFFF_FFFC || grant_addr[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: grants=%0d required fffffffc then 00000000", grant_addr.size());
    end
    checks++;
    if (deliv_pc.size() < 2 || deliv_pc[0] !== 32'h0 || deliv_pc[1] !== 32'h4) begin
      errors++;
      $display("FAIL wrap_pc: delivered=%0d required PCs 00000000 then 00000004", deliv_pc.size());
    end
  endtask

  task automatic test_delay_slot();
    gnt_pct = 100; lat_min = 2; lat_max = 2;
    do_reset();
    step(1'b0, 1'b1, 1'b1, 32'h0000_0020);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (s_grant !== 1'b1 || s_addr !== 32'h0000_0020) begin
      errors++;
      $display("FAIL slot_setup: grant=%b addr=%h required 1 00000020", s_grant, s_addr);
    end
    step(1'b0, 1'b1, 1'b1, 32'h0000_0300);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
`ifdef IF_DELAY_SLOT_EN
    if (deliv_pc.size() < 2 || deliv_pc[0] !== 32'h0000_0024 || deliv_pc[1] !== 32'h0000_0304) begin
      errors++;
      $display("FAIL slot_order: delivered=%0d required PCs 00000024 then 00000304", deliv_pc.size());
    end
`else
    if (deliv_pc.size() < 1 || deliv_pc[0] !== 32'h0000_0304) begin
      errors++;
      $display("FAIL slot_flush: delivered=%0d first PC required 00000304", deliv_pc.size());
    end
`endif
  endtask

  task automatic test_random();
    int start;
    logic r, en, rd;
    logic [31:0] rpc;
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    do_reset();
    start = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(999) == 0);
      en = ($urandom_range(99) < 75);
      rd = ($urandom_range(99) < 5);
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h0000_000C);
      step(r, en, rd, rpc);
    end
    checks++;
    if (n_deliv - start < 200) begin
      errors++;
      $display("FAIL random_progress: delivered=%0d required >=200", n_deliv - start);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_hold();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_wrap();
    test_delay_slot();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
